// File: rtl/iopage_ctl.sv
// I/O-page bus sequencer: latches one CPU access, broadcasts it to the device
// blocks, returns the lowest-index decoder's read data or times out with NXM.
module iopage_ctl #(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic [12:0]          cpu_addr,
  input  logic                 cpu_wr,
  input  logic                 cpu_byte_op,
  input  logic [15:0]          cpu_data_in,
  output logic                 cpu_ack,
  output logic                 cpu_nxm,
  output logic [15:0]          cpu_data_out,
  output logic                 busy,
  output logic [12:0]          iopage_addr,
  output logic [15:0]          iopage_data_out,
  output logic                 iopage_rd,
  output logic                 iopage_wr,
  output logic                 iopage_byte_op,
  input  logic [NDEV-1:0]      dev_decode,
  input  logic [16*NDEV-1:0]   dev_data,
  output logic                 conflict
);

  localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ACCESS,
    S_DONE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_wr;
  logic [SEL_W-1:0] r_sel;
  logic [7:0]       r_cnt;
  logic [SEL_W-1:0] w_sel;
  logic             w_hit;
  logic             w_multi;
  logic [15:0]      w_rdata;

  // Scan from the top so the lowest asserted decode line ends up selected.
  always_comb begin
    w_sel   = '0;
    w_hit   = 1'b0;
    w_multi = 1'b0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (dev_decode[i]) begin
        w_multi = w_multi | w_hit;
        w_hit   = 1'b1;
        w_sel   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (r_sel == SEL_W'(i)) w_rdata = dev_data[16*i +: 16];
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    cpu_ack   = 1'b0;
    cpu_nxm   = 1'b0;
    iopage_rd = 1'b0;
    iopage_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (cpu_req) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_hit ? S_ACCESS : S_WAIT;
      S_ACCESS: begin
        iopage_rd = ~r_wr;
        iopage_wr = r_wr;
        w_next    = S_DONE;
      end
      S_DONE: begin
        cpu_ack = 1'b1;
        w_next  = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) begin
          cpu_nxm = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_wr            <= 1'b0;
      r_sel           <= '0;
      r_cnt           <= '0;
      iopage_addr     <= '0;
      iopage_data_out <= '0;
      iopage_byte_op  <= 1'b0;
      cpu_data_out    <= '0;
      conflict        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_req) begin
        iopage_addr     <= cpu_addr;
        iopage_data_out <= cpu_data_in;
        iopage_byte_op  <= cpu_byte_op;
        r_wr            <= cpu_wr;
      end
      if (r_state == S_DECODE) begin
        if (w_hit) r_sel <= w_sel;
        else       r_cnt <= 8'(TIMEOUT - 1);
        if (w_multi) conflict <= 1'b1;
      end
      if (r_state == S_WAIT && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      // Write accesses leave the last read value visible to the CPU.
      if (r_state == S_ACCESS && !r_wr) cpu_data_out <= w_rdata;
    end
  end

endmodule

// File: tb/tb_iopage_ctl.sv
// Scoreboard bench for iopage_ctl: a driver pushes predicted outcomes from an
// address-map model; a monitor checks strobes and completions as they appear.
module tb_iopage_ctl;
  localparam int NDEV = 4;
  localparam int TMO  = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cpu_req = 1'b0;
  logic [12:0]        cpu_addr = '0;
  logic               cpu_wr = 1'b0;
  logic               cpu_byte_op = 1'b0;
  logic [15:0]        cpu_data_in = '0;
  logic               cpu_ack, cpu_nxm, busy, iopage_rd, iopage_wr, iopage_byte_op, conflict;
  logic [15:0]        cpu_data_out, iopage_data_out;
  logic [12:0]        iopage_addr;
  logic [NDEV-1:0]    dev_decode;
  logic [16*NDEV-1:0] dev_data;

  iopage_ctl #(.NDEV(NDEV), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_byte_op(cpu_byte_op), .cpu_data_in(cpu_data_in),
    .cpu_ack(cpu_ack), .cpu_nxm(cpu_nxm), .cpu_data_out(cpu_data_out), .busy(busy),
    .iopage_addr(iopage_addr), .iopage_data_out(iopage_data_out),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .dev_decode(dev_decode), .dev_data(dev_data), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic dup_en = 1'b0;
  logic mon_en = 1'b0;

  // Device blocks: switch register, 4-word RAM, address-derived ROM, constant register.
  logic [15:0] ram1 [4];
  always_comb begin
    dev_decode      = '0;
    dev_data        = '0;
    dev_decode[0]   = (iopage_addr == 13'o17570);
    dev_data[15:0]  = 16'o123456;
    dev_decode[1]   = (iopage_addr[12:3] == 10'o1756);
    dev_data[31:16] = ram1[iopage_addr[2:1]];
    dev_decode[2]   = (iopage_addr[12:6] == 7'o177);
    dev_data[47:32] = {3'b000, iopage_addr} ^ 16'hA5A5;
    dev_decode[3]   = (iopage_addr[12:6] == 7'o174) || (dup_en && iopage_addr == 13'o17566);
    dev_data[63:48] = 16'h3333;
  end
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4; i++) ram1[i] <= '0;
    end else if (iopage_wr && dev_decode[1]) begin
      ram1[iopage_addr[2:1]] <= iopage_data_out;
    end
  end

  typedef struct {
    logic        nxm;
    logic        wr;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        bop;
    logic [15:0] dout;
    logic        conf;
    int          acc;
  } exp_t;
  exp_t q[$];

  // Reference model state: RAM image, last read value, sticky conflict.
  logic [15:0] mram [4];
  logic [15:0] mlast;
  logic        mconf;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [12:0] a, input logic w, input logic [15:0] d,
                       input logic b, input logic hold);
    exp_t        e;
    logic [3:0]  cl;
    logic [15:0] rd;
    int          idx;
    logic        done;
    cpu_req     = 1'b1;
    cpu_addr    = a;
    cpu_wr      = w;
    cpu_data_in = d;
    cpu_byte_op = b;
    cl[0] = (a == 13'o17570);
    cl[1] = (a >= 13'o17560) && (a <= 13'o17567);
    cl[2] = (a >= 13'o17700);
    cl[3] = ((a >= 13'o17400) && (a <= 13'o17477)) || (dup_en && a == 13'o17566);
    idx   = (int'(a) - int'(13'o17560)) / 2;
    if ($countones(cl) > 1) mconf = 1'b1;
    e.nxm = (cl == 4'b0000);
    if (!e.nxm) begin
      if (cl[0])      rd = 16'o123456;
      else if (cl[1]) rd = mram[idx];
      else if (cl[2]) rd = {3'b000, a} ^ 16'hA5A5;
      else            rd = 16'h3333;
      if (w) begin
        if (cl[1]) mram[idx] = d;
      end else begin
        mlast = rd;
      end
    end
    e.wr = w; e.addr = a; e.wdata = d; e.bop = b;
    e.dout = mlast; e.conf = mconf; e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    check("busy_accept", busy, 1);
    done = 1'b0;
    for (int k = 0; k < TMO + 20; k++) begin
      if (cpu_ack || cpu_nxm) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      check("completion_timeout", 0, 1);
      q.delete();
    end
    if (!hold) cpu_req = 1'b0;
  endtask

  exp_t me;
  int   nstrb = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (iopage_rd || iopage_wr) begin
          check("strobe_exclusive", iopage_rd & iopage_wr, 0);
          if (q.size() == 0) begin
            check("spurious_strobe", 1, 0);
          end else begin
            check("strobe_latency", cyc - q[0].acc + 1, 2);
            check("strobe_is_write", iopage_wr, q[0].wr);
            check("strobe_addr", iopage_addr, q[0].addr);
            if (q[0].wr) begin
              check("wr_data", iopage_data_out, q[0].wdata);
              check("wr_byte_op", iopage_byte_op, q[0].bop);
            end
          end
          nstrb++;
        end
        if (cpu_ack || cpu_nxm) begin
          check("ack_nxm_exclusive", cpu_ack & cpu_nxm, 0);
          if (q.size() == 0) begin
            check("spurious_completion", 1, 0);
          end else begin
            me = q.pop_front();
            check("nxm_kind", cpu_nxm, me.nxm);
            check("done_latency", cyc - me.acc + 1, me.nxm ? 1 + TMO : 3);
            check("strobe_count", nstrb, me.nxm ? 0 : 1);
            check("cpu_data_out", cpu_data_out, me.dout);
            check("conflict", conflict, me.conf);
            check("busy_done", busy, 1);
          end
          nstrb = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [12:0] ra;
  initial begin
    for (int i = 0; i < 4; i++) mram[i] = '0;
    mlast = '0;
    mconf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", cpu_ack, 0);
    check("rst_nxm", cpu_nxm, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", iopage_rd, 0);
    check("rst_wr", iopage_wr, 0);
    check("rst_addr", iopage_addr, 0);
    check("rst_wdata", iopage_data_out, 0);
    check("rst_bop", iopage_byte_op, 0);
    check("rst_dout", cpu_data_out, 0);
    check("rst_conflict", conflict, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    issue(13'o17570, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    issue(13'o17566, 1'b1, 16'o000377, 1'b1, 1'b0);
    @(negedge clk);
    issue(13'o17566, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    issue(13'o17000, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);

    issue(13'o17566, 1'b1, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    dup_en = 1'b1;
    issue(13'o17566, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    dup_en = 1'b0;
    issue(13'o17570, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0:       ra = 13'o17570;
        1:       ra = 13'o17560 + 13'(2 * $urandom_range(0, 3));
        2:       ra = 13'o17700 + 13'($urandom_range(0, 63));
        3:       ra = 13'o17400 + 13'($urandom_range(0, 63));
        default: ra = 13'($urandom_range(0, 13'o17377));
      endcase
      issue(ra, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Request held high: re-accepted after exactly one idle cycle.
    for (int i = 0; i < 4; i++) begin
      issue(13'o17702, 1'b0, 16'h0, 1'b0, i < 3);
      @(negedge clk);
      if (i < 3) check("busy_gap", busy, 0);
    end

    mon_en  = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 13'o17570;
    cpu_wr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_rd_before", iopage_rd, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rd_async", iopage_rd, 0);
    check("abort_busy_async", busy, 0);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", cpu_ack | cpu_nxm, 0);
    end
    check("abort_dout", cpu_data_out, 0);
    check("abort_conflict", conflict, 0);
    mlast   = '0;
    mconf   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    issue(13'o17570, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iopage_ctl.md
Name: iopage_ctl

Overview:
- Sequences CPU accesses to I/O-page device register blocks (switch register, console, clocks, etc.) and shares the single iopage bus between them.
- Latches one CPU request and drives iopage_addr/rd/wr/byte_op to all devices.
- Selects the responding device via its decode line and returns read data.
- Signals a non-existent-memory (NXM) bus timeout when no device decodes the address.

Parameters:
NDEV, 4, number of attached device blocks (1..16)
TIMEOUT, 8, cycles waited after decode miss before cpu_nxm (2..255)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  access request; held by CPU until cpu_ack or cpu_nxm
cpu_addr  in  13  I/O-page word/byte address (offset within 8 KB page)
cpu_wr  in  1  1=write, 0=read
cpu_byte_op  in  1  byte access qualifier, passed through
cpu_data_in  in  16  write data
cpu_ack  out  1  one-cycle pulse, access completed
cpu_nxm  out  1  one-cycle pulse, bus timeout (CPU traps to 4)
cpu_data_out  out  16  read data, valid with cpu_ack, held until next acceptance
busy  out  1  high from acceptance until the ack/nxm cycle inclusive
iopage_addr  out  13  registered address to devices
iopage_data_out  out  16  registered write data to devices
iopage_rd  out  1  read strobe, one cycle
iopage_wr  out  1  write strobe, one cycle
iopage_byte_op  out  1  registered byte qualifier
dev_decode  in  NDEV  per-device combinational decode of iopage_addr
dev_data  in  16*NDEV  per-device read data, device i at bits [16i+15:16i]
conflict  out  1  sticky: more than one decode seen in one access

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0, including iopage_addr, cpu_data_out and conflict. Strobes drop immediately, even mid-access. No ack/nxm is issued for an aborted request.
- States: IDLE, DECODE, ACCESS, DONE, WAIT.
- IDLE:
  - busy=0.
  - If cpu_req=1 at a clock edge, latch cpu_addr, cpu_wr, cpu_byte_op and cpu_data_in into the iopage_* registers; go to DECODE.
- DECODE:
  - Strobes=0; devices decode the stable address.
  - At the edge, if |dev_decode, record sel = lowest-index asserted bit and go to ACCESS.
  - Otherwise load the counter with TIMEOUT-1 and go to WAIT.
  - If popcount(dev_decode)>1, set conflict (cleared only by reset). Lowest index still wins.
- ACCESS:
  - Exactly one of iopage_rd/iopage_wr =1 for one cycle, per latched cpu_wr.
  - On read, capture dev_data[sel] into cpu_data_out at the edge.
  - On write, cpu_data_out is unchanged.
  - Go to DONE.
- DONE: cpu_ack=1 for one cycle; go to IDLE.
- WAIT:
  - Counter decrements each cycle; no strobes are issued.
  - When counter=0, cpu_nxm=1 for that cycle; go to IDLE.
  - Decode is not re-sampled.
  - cpu_data_out is unchanged.
- Latency:
  - Request sampled at edge N: rd/wr strobe in cycle N+2, cpu_ack in cycle N+3.
  - Decode miss: cpu_nxm asserted TIMEOUT cycles after DECODE, i.e. cycle N+1+TIMEOUT.
- cpu_req during busy is ignored; no queueing.
- The CPU deasserts cpu_req in the ack/nxm cycle; a request still high in IDLE is a new access.
- iopage_addr, iopage_data_out and iopage_byte_op hold their last values in IDLE. Strobes are never both high.
- cpu_ack and cpu_nxm are never both high.

Test Plan:
1. Device 0 = switch register at 13'o17570 with switches=16'o123456; read 17570 -> iopage_rd single cycle at N+2, cpu_ack at N+3, cpu_data_out=16'o123456, cpu_nxm never high.
2. Write 16'o000377 to a RAM-like device 1 at 13'o17566, cpu_byte_op=1 -> iopage_wr one cycle with iopage_data_out=16'o000377, iopage_byte_op=1; cpu_ack at N+3; read back returns 16'o000377.
3. Read 13'o17000 (no decode), TIMEOUT=8 -> no strobes, cpu_nxm pulse at N+9, cpu_ack=0, cpu_data_out retains previous value.
4. Devices 1 and 3 both decode the same address, data 16'h1111/16'h3333 -> cpu_data_out=16'h1111, conflict=1 and remains set across later accesses.
5. Assert reset_n=0 during ACCESS -> iopage_rd falls without waiting for a clock edge, no cpu_ack; after release, state IDLE and the next read completes normally at N+3.
6. Hold cpu_req high continuously -> back-to-back accesses accepted every 4 cycles (ack, then re-accept the cycle after), busy low exactly one cycle between.
